branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters. Selectable bimodal or gshare indexing. Sits beside fetch: a combinational lookup on the fetch PC redirects next-PC to the predicted target. Execute resolves branches and writes updates, so taken branches and jumps no longer always cost a flush.

Parameters:
PC_WIDTH, 32, PC and target width
ENTRIES, 64, table entries; power of two, at least 4; IDX_W = log2(ENTRIES)
TAG_WIDTH, 8, stored tag bits taken from pc[IDX_W+2 +: TAG_WIDTH]
GSHARE, 0, 0 = bimodal index; 1 = index XOR global history
GHR_WIDTH, IDX_W, global history length; must be at most IDX_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (asserted at 0)
lookup_pc  in  PC_WIDTH  fetch-stage PC
pred_taken  out  1  predicted taken (hit and counter[1]=1)
pred_target  out  PC_WIDTH  stored target if pred_taken, else lookup_pc+4
pred_ghr  out  GHR_WIDTH  history snapshot used for this lookup; carried down the pipe
upd_en  in  1  execute resolves a control-flow instruction this cycle
upd_pc  in  PC_WIDTH  PC of resolved instruction
upd_ghr  in  GHR_WIDTH  pred_ghr carried with the instruction
upd_is_jump  in  1  unconditional jump (jal/jalr)
upd_taken  in  1  actual outcome
upd_target  in  PC_WIDTH  actual target
upd_mispredict  in  1  prediction was wrong (direction or target)
branch_count  out  32  resolved control-flow instructions
mispredict_count  out  32  mispredictions

Behaviour:
- Index: idx = lookup_pc[IDX_W+1:2].
  - If GSHARE=1, XOR the low GHR_WIDTH bits of idx with ghr.
  - Update side: same function on upd_pc and upd_ghr.
- Tag: pc[IDX_W+2 +: TAG_WIDTH]. Hit = valid[idx] and tag match.
- Lookup is combinational from registered table state (zero latency).
  - pred_ghr = current ghr register.
  - On a miss, pred_taken=0.
- Reset (rst=0, async), values hold until the first rising edge after rst=1:
  - all valid=0, all counters=2'b01, ghr=0, both perf counters=0.
  - Tags and targets are not reset.
  - Outputs: pred_taken=0, pred_target=lookup_pc+4, pred_ghr=0, counts=0.
- Update (rising edge with upd_en=1):
  - Miss: allocate the entry: valid=1, tag and target written. Counter = 2'b11 if upd_is_jump, else 2'b10 if upd_taken, else 2'b01.
  - Hit, conditional branch: counter increments if taken (saturates at 11), decrements if not (saturates at 00). Target is overwritten only when taken.
  - Hit, jump: counter forced to 2'b11, target overwritten.
  - ghr = {ghr[GHR_WIDTH-2:0], upd_taken} only when upd_is_jump=0. History is non-speculative and changes at resolution only.
  - branch_count += 1. mispredict_count += upd_mispredict. Both wrap modulo 2^32.
- upd_en=0: no state change; all other upd_* inputs are ignored.
- Same-cycle lookup and update to the same index: lookup returns pre-update state (no bypass). The new state is visible the next cycle.
- Allocation on a miss evicts any resident entry with a different tag (direct-mapped, no replacement policy).
- Stalls and flushes do not touch this block; the pipeline alone decides whether to use the prediction.
- Reset asserted mid-operation: immediate clear as above; an update on that edge is discarded.
- Not-taken branches that miss are still allocated, so entries with counter 01 predict not-taken.

Decomposition:
- Shared package holds: counter encoding constants (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11), the entry struct (valid, tag, target, ctr), and the saturating-counter next-state function.
- One sub-module, bp_sat_counter, is natural (2-bit next-state logic, parametrised by width). The table stays inline as a register array.

Test Plan:
- Reset then lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, pred_ghr=0, counts=0.
- Update pc=0x100, taken, target=0x80, not jump (miss) -> next cycle lookup 0x100 gives pred_taken=1, pred_target=0x80; branch_count=1.
- Saturation:
  - Same branch: 3 taken updates, then 1 not-taken -> still predicts taken (11 to 10).
  - Then 2 more not-taken -> pred_taken=0 (00); a further not-taken stays at 00.
- Jump at 0x200 to 0x40 with upd_is_jump -> counter=11 and ghr unchanged. Aliasing pc 0x200+4*ENTRIES with a different tag -> miss (pred_taken=0) until allocated, which evicts 0x200.
- GSHARE=1, ENTRIES=16: ghr=4'b1010, lookup 0x10 -> idx=4^10=14. Update with upd_ghr=4'b1010 writes entry 14, and a later lookup with the same ghr hits.
- Simultaneous update and lookup of 0x100 on one edge -> that cycle shows old prediction, the next cycle shows new. mispredict_count from 0xFFFFFFFF with upd_mispredict=1 -> wraps to 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch target buffer: counter encoding,
// saturating next-state and allocation policy.
package branch_predictor_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t STRONG_NT = 2'b00;
   localparam ctr_t WEAK_NT   = 2'b01;
   localparam ctr_t WEAK_T    = 2'b10;
   localparam ctr_t STRONG_T  = 2'b11;

   function automatic ctr_t sat_next(input ctr_t cur, input logic inc);
      ctr_t nxt;
      nxt = cur;
      if (inc && cur != STRONG_T)
         nxt = cur + 2'd1;
      else if (!inc && cur != STRONG_NT)
         nxt = cur - 2'd1;
      return nxt;
   endfunction

   // Fresh entries start biased toward the outcome that caused the allocation
   function automatic ctr_t alloc_ctr(input logic is_jump, input logic taken);
      if (is_jump)
         return STRONG_T;
      else if (taken)
         return WEAK_T;
      else
         return WEAK_NT;
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Width-generic saturating up/down counter next-state logic.
module bp_sat_counter #(
   parameter int W = 2
) (
   input  logic [W-1:0] cur,
   input  logic         inc,
   output logic [W-1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (inc && cur != '1)
         nxt = cur + W'(1);
      else if (!inc && cur != '0)
         nxt = cur - W'(1);
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; combinational lookup,
// single update port from execute, bimodal or gshare indexing.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int PC_WIDTH  = 32,
   parameter int ENTRIES   = 64,
   parameter int TAG_WIDTH = 8,
   parameter int GSHARE    = 0,
   parameter int GHR_WIDTH = $clog2(ENTRIES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PC_WIDTH-1:0]  lookup_pc,
   output logic                 pred_taken,
   output logic [PC_WIDTH-1:0]  pred_target,
   output logic [GHR_WIDTH-1:0] pred_ghr,
   input  logic                 upd_en,
   input  logic [PC_WIDTH-1:0]  upd_pc,
   input  logic [GHR_WIDTH-1:0] upd_ghr,
   input  logic                 upd_is_jump,
   input  logic                 upd_taken,
   input  logic [PC_WIDTH-1:0]  upd_target,
   input  logic                 upd_mispredict,
   output logic [31:0]          branch_count,
   output logic [31:0]          mispredict_count
);

   localparam int IDX_W = $clog2(ENTRIES);

   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
      logic [PC_WIDTH-1:0]  target;
      ctr_t                 ctr;
   } entry_t;

   entry_t               tbl [ENTRIES];
   logic [GHR_WIDTH-1:0] ghr;

   function automatic logic [IDX_W-1:0] index_of(input logic [PC_WIDTH-1:0]  pc,
                                                  input logic [GHR_WIDTH-1:0] h);
      logic [IDX_W-1:0] idx;
      idx = pc[IDX_W+1:2];
      if (GSHARE != 0)
         idx = idx ^ IDX_W'(h);
      return idx;
   endfunction

   // Lookup side
   logic [IDX_W-1:0] l_idx;
   entry_t           l_ent;
   logic             l_hit;

   assign l_idx       = index_of(lookup_pc, ghr);
   assign l_ent       = tbl[l_idx];
   assign l_hit       = l_ent.valid && (l_ent.tag == lookup_pc[IDX_W+2 +: TAG_WIDTH]);
   assign pred_taken  = l_hit && l_ent.ctr[1];
   assign pred_target = pred_taken ? l_ent.target : lookup_pc + PC_WIDTH'(4);
   assign pred_ghr    = ghr;

   // Update side
   logic [IDX_W-1:0] u_idx;
   entry_t           u_ent;
   logic             u_hit;
   ctr_t             u_sat;
   ctr_t             u_ctr;
   logic             u_wr_tgt;

   assign u_idx = index_of(upd_pc, upd_ghr);
   assign u_ent = tbl[u_idx];
   assign u_hit = u_ent.valid && (u_ent.tag == upd_pc[IDX_W+2 +: TAG_WIDTH]);

   bp_sat_counter #(.W(2)) u_sat_ctr (
      .cur (u_ent.ctr),
      .inc (upd_taken),
      .nxt (u_sat)
   );

   always_comb begin
      u_ctr = u_sat;
      if (!u_hit)
         u_ctr = alloc_ctr(upd_is_jump, upd_taken);
      else if (upd_is_jump)
         u_ctr = STRONG_T;
   end

   // A not-taken hit keeps the old target so a later taken flip still redirects
   assign u_wr_tgt = !u_hit || upd_is_jump || upd_taken;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i].valid <= 1'b0;
            tbl[i].ctr   <= WEAK_NT;
         end
         ghr              <= '0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (upd_en) begin
         tbl[u_idx].valid <= 1'b1;
         tbl[u_idx].tag   <= upd_pc[IDX_W+2 +: TAG_WIDTH];
         tbl[u_idx].ctr   <= u_ctr;
         if (u_wr_tgt)
            tbl[u_idx].target <= upd_target;
         if (!upd_is_jump)
            ghr <= (ghr << 1) | GHR_WIDTH'(upd_taken);
         branch_count     <= branch_count + 32'd1;
         mispredict_count <= mispredict_count + {31'b0, upd_mispredict};
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = &{1'b0, lookup_pc, upd_pc};

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: bimodal (64 entries) and gshare (16 entries) instances
// driven with directed and random traffic, checked against an array model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lookup_pc, upd_pc, upd_target;
   logic        upd_en, upd_is_jump, upd_taken, upd_mispredict;
   logic [5:0]  upd_ghr0, pg0;
   logic [3:0]  upd_ghr1, pg1;
   logic        pt0, pt1;
   logic [31:0] ptg0, ptg1, bc0, bc1, mc0, mc1;

   always #5 clk = ~clk;

   branch_predictor u_bim (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
      .pred_taken(pt0), .pred_target(ptg0), .pred_ghr(pg0),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_ghr(upd_ghr0),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict),
      .branch_count(bc0), .mispredict_count(mc0)
   );

   branch_predictor #(.ENTRIES(16), .GSHARE(1), .GHR_WIDTH(4)) u_gsh (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
      .pred_taken(pt1), .pred_target(ptg1), .pred_ghr(pg1),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_ghr(upd_ghr1),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict),
      .branch_count(bc1), .mispredict_count(mc1)
   );

   // Reference model: per-instance table with counter strength 0..3
   int          ents [2] = '{64, 16};
   int          ib   [2] = '{6, 4};
   int          gw   [2] = '{6, 4};
   bit          gs   [2] = '{1'b0, 1'b1};
   bit          m_v   [2][64];
   logic [31:0] m_tgt [2][64];
   int          m_tag [2][64];
   int          m_str [2][64];
   int          m_ghr [2];
   logic [31:0] m_bc, m_mc;

   typedef struct {
      bit          t0;
      logic [31:0] tg0;
      int          g0;
      bit          t1;
      logic [31:0] tg1;
      int          g1;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   function automatic int m_idx(int d, logic [31:0] pc, int h);
      int i;
      i = int'({2'b00, pc[31:2]}) % ents[d];
      if (gs[d]) i = i ^ h;
      return i;
   endfunction

   function automatic int m_tagof(int d, logic [31:0] pc);
      return int'((pc >> (ib[d] + 2)) & 32'hFF);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ghr[d] = 0;
         for (int i = 0; i < 64; i++) begin
            m_v[d][i]   = 1'b0;
            m_str[d][i] = 1;
         end
      end
      m_bc = 0;
      m_mc = 0;
   endtask

   task automatic model_update(int d, logic [31:0] pc, int h, bit tk, bit jp, logic [31:0] tgt);
      int  i;
      bit  hit;
      i   = m_idx(d, pc, h);
      hit = m_v[d][i] && m_tag[d][i] == m_tagof(d, pc);
      if (!hit) begin
         m_v[d][i]   = 1'b1;
         m_tag[d][i] = m_tagof(d, pc);
         m_tgt[d][i] = tgt;
         m_str[d][i] = jp ? 3 : (tk ? 2 : 1);
      end else if (jp) begin
         m_str[d][i] = 3;
         m_tgt[d][i] = tgt;
      end else begin
         m_str[d][i] = tk ? ((m_str[d][i] < 3) ? m_str[d][i] + 1 : 3)
                          : ((m_str[d][i] > 0) ? m_str[d][i] - 1 : 0);
         if (tk) m_tgt[d][i] = tgt;
      end
      if (!jp) m_ghr[d] = ((m_ghr[d] << 1) | int'(tk)) & ((1 << gw[d]) - 1);
   endtask

   function automatic void model_pred(int d, logic [31:0] pc, output bit t, output logic [31:0] tg);
      int i;
      i  = m_idx(d, pc, m_ghr[d]);
      t  = m_v[d][i] && m_tag[d][i] == m_tagof(d, pc) && m_str[d][i] >= 2;
      tg = t ? m_tgt[d][i] : pc + 32'd4;
   endfunction

   // One cycle of stimulus; uh < 0 means carry the model's current history
   task automatic cyc(logic [31:0] lpc, bit en, logic [31:0] upc, bit tk, bit jp,
                      logic [31:0] tgt, bit mis, int uh0 = -1, int uh1 = -1);
      exp_t e;
      int   h0, h1;
      h0 = (uh0 < 0) ? m_ghr[0] : uh0;
      h1 = (uh1 < 0) ? m_ghr[1] : uh1;
      lookup_pc      = lpc;
      upd_en         = en;
      upd_pc         = upc;
      upd_taken      = tk;
      upd_is_jump    = jp;
      upd_target     = tgt;
      upd_mispredict = mis;
      upd_ghr0       = 6'(h0);
      upd_ghr1       = 4'(h1);
      model_pred(0, lpc, e.t0, e.tg0);
      model_pred(1, lpc, e.t1, e.tg1);
      e.g0 = m_ghr[0];
      e.g1 = m_ghr[1];
      e.bc = m_bc;
      e.mc = m_mc;
      q.push_back(e);
      if (rst && en) begin
         model_update(0, upc, h0, tk, jp, tgt);
         model_update(1, upc, h1, tk, jp, tgt);
         m_bc = m_bc + 1;
         m_mc = m_mc + 32'(mis);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic look(logic [31:0] lpc);
      cyc(lpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are combinational, so compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("bim_taken",  64'(pt0),  64'(e.t0));
            chk("bim_target", 64'(ptg0), 64'(e.tg0));
            chk("bim_ghr",    64'(pg0),  64'(e.g0));
            chk("bim_bcnt",   64'(bc0),  64'(e.bc));
            chk("bim_mcnt",   64'(mc0),  64'(e.mc));
            chk("gsh_taken",  64'(pt1),  64'(e.t1));
            chk("gsh_target", 64'(ptg1), 64'(e.tg1));
            chk("gsh_ghr",    64'(pg1),  64'(e.g1));
            chk("gsh_bcnt",   64'(bc1),  64'(e.bc));
            chk("gsh_mcnt",   64'(mc1),  64'(e.mc));
         end
      end
   end

   function automatic logic [31:0] rpc();
      return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
   endfunction

   initial begin
      int wait_cyc;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      look(32'h100);                                   // held in reset
      rst = 1'b1;
      look(32'h100);                                   // reset state after release

      cyc(32'h100, 1, 32'h100, 1, 0, 32'h80, 1);       // allocate; same-cycle shows old
      look(32'h100);                                   // now taken to 0x80
      repeat (3) cyc(32'h100, 1, 32'h100, 1, 0, 32'h80, 0);
      cyc(32'h100, 1, 32'h100, 0, 0, 32'h0, 1);        // 11 -> 10
      look(32'h100);
      repeat (3) cyc(32'h100, 1, 32'h100, 0, 0, 32'h0, 1);
      cyc(32'h100, 1, 32'h100, 1, 0, 32'h80, 1);       // 00 -> 01 still not taken
      look(32'h100);

      cyc(32'h200, 1, 32'h200, 1, 1, 32'h40, 0);       // jump: history untouched
      look(32'h200);
      look(32'h300);                                   // alias, different tag
      cyc(32'h300, 1, 32'h300, 1, 0, 32'h500, 0);
      look(32'h200);
      look(32'h300);

      // Drive gshare history to 4'b1010
      cyc(32'h10, 1, 32'h400, 1, 0, 32'h0, 0);
      cyc(32'h10, 1, 32'h400, 0, 0, 32'h0, 0);
      cyc(32'h10, 1, 32'h400, 1, 0, 32'h0, 0);
      cyc(32'h10, 1, 32'h400, 0, 0, 32'h0, 0);
      cyc(32'h10, 1, 32'h10, 1, 0, 32'h900, 0, -1, 4'b1010);
      cyc(32'h10, 1, 32'h400, 0, 0, 32'h0, 0);         // history back to 1010
      look(32'h10);

      for (int n = 0; n < 400; n++) begin
         bit jp, tk;
         int h0, h1;
         if (n == 200) begin
            rst = 1'b0;
            model_reset();
            cyc(rpc(), 1, rpc(), 1, 0, 32'h1234, 1);  // update on a reset edge is lost
            rst = 1'b1;
         end
         jp = ($urandom_range(0, 5) == 0);
         tk = jp || ($urandom_range(0, 1) == 1);
         h0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : -1;
         h1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
         cyc(rpc(), $urandom_range(0, 2) != 0, rpc(), tk, jp,
             $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, h0, h1);
      end

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
